i2c_target_responder: RTL and testbench



---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_line_cond.sv | 74 +++++++
 rtl/i2c_target_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target responder:
//               responder state enum, address/data widths, R/W encoding.
// Options     : I2C_RESP_GLITCH_FILTER_EN (used by i2c_line_cond)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  // R/W bit encoding, identical to the one used by the i2c BFM
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_MACK
  } i2c_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_line_cond.sv
// ============================================================================
// Module      : i2c_line_cond
// Description : Conditions one I2C line: 2-FF synchronizer, optional
//               persistence glitch filter, rise/fall detection.
// Options     : I2C_RESP_GLITCH_FILTER_EN enables the FILT_CYCLES filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_cond #(
  parameter int FILT_CYCLES = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

`ifdef I2C_RESP_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif
  localparam int FILT_LEN = FILT_EN ? FILT_CYCLES : 0;

  logic [1:0] sync_q;
  logic       prev_q;
  logic       w_level;

  // Two-flop synchronizer; the bus idles high so reset to 1
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], line_i};
  end

  if (FILT_LEN > 0) begin : g_filt
    localparam int CW = $clog2(FILT_LEN + 1);
    logic          filt_q;
    logic [CW-1:0] cnt_q;

    // Accept a new level only after it persisted FILT_LEN consecutive cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else if (sync_q[1] == filt_q) begin
        cnt_q  <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
    assign w_level = filt_q;
  end else begin : g_bypass
    assign w_level = sync_q[1];
  end

  // Previous level for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) prev_q <= 1'b1;
    else          prev_q <= w_level;
  end

  assign level_o = w_level;
  assign rise_o  = w_level & ~prev_q;
  assign fall_o  = ~w_level & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target_responder.sv
// ============================================================================
// Module      : i2c_target_responder
// Description : I2C target with a small byte-addressed register file. A write
//               sets the pointer then stores bytes; a read returns bytes from
//               the pointer. Strobes expose stored and fetched bytes.
// Options     : I2C_RESP_GLITCH_FILTER_EN adds a FILT_CYCLES line filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h22,
  parameter int                        MEM_DEPTH   = 16,
  parameter int                        FILT_CYCLES = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_o,
  output logic                         busy_o,
  output logic                         wr_stb_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_ptr_o,
  output logic [I2C_DATA_WIDTH-1:0]    wr_data_o,
  output logic                         rd_stb_o,
  output logic [I2C_DATA_WIDTH-1:0]    rd_data_o
);

  localparam int PW = $clog2(MEM_DEPTH);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic w_scl_steady_hi, w_start, w_stop;

  i2c_resp_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            sda_q, sda_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic            rd_stb_q, rd_stb_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic [7:0]      mem_q [MEM_DEPTH];
  logic            mem_we, rd_load;
  logic [7:0]      w_byte;

  i2c_line_cond #(.FILT_CYCLES(FILT_CYCLES)) u_scl_cond (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_cond #(.FILT_CYCLES(FILT_CYCLES)) u_sda_cond (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .line_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // An sda edge coinciding with an scl edge is never START/STOP
  assign w_scl_steady_hi = scl_lvl & ~scl_rise & ~scl_fall;
  assign w_start         = sda_fall & w_scl_steady_hi;
  assign w_stop          = sda_rise & w_scl_steady_hi;
  assign w_byte          = {shift_q[6:0], sda_lvl};

  // Next-state, bus drive and strobe generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    rd_stb_d  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    if (w_stop) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (w_start) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_ADDR, ST_PTR, ST_WR_BYTE: begin
          if (scl_fall) sda_d = 1'b1;
          if (scl_rise) begin
            shift_d = w_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = w_byte[0];
                end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = w_byte[PW-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                mem_we    = 1'b1;
                wr_stb_d  = 1'b1;
                wr_ptr_d  = ptr_q;
                wr_data_d = w_byte;
                state_d   = ST_WR_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) sda_d = 1'b0;
          if (scl_rise) begin
            cnt_d = '0;
            if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
              rd_load = 1'b1;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WR_BYTE;
              if (state_q == ST_WR_ACK) ptr_d = ptr_q + 1'b1;
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise && cnt_q != 4'd8) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_d   = 1'b1;
              state_d = ST_RD_MACK;
            end else begin
              sda_d   = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        ST_RD_MACK: begin
          if (scl_rise) begin
            if (sda_lvl) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              rd_load = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Fetch the next byte for transmission and advance the pointer
    if (rd_load) begin
      shift_d   = mem_q[ptr_q];
      rd_data_d = mem_q[ptr_q];
      rd_stb_d  = 1'b1;
      ptr_d     = ptr_q + 1'b1;
      cnt_d     = '0;
      state_d   = ST_RD_BYTE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= I2C_RW_WRITE;
      sda_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      rd_stb_q  <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      rd_stb_q  <= rd_stb_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Register file, cleared on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= w_byte;
    end
  end

  // Reset releases the bus immediately, without waiting for a clock
  assign sda_o     = sda_q | ~rst_n_i;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_ptr_o  = wr_ptr_q;
  assign wr_data_o = wr_data_q;
  assign rd_stb_o  = rd_stb_q;
  assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
// ============================================================================
// Module      : tb_i2c_target_responder
// Description : Self-checking bench: bit-level I2C master, register-file
//               model with expected-strobe queues, per-cycle compare process.
// Options     : I2C_RESP_GLITCH_FILTER_EN changes the glitch expectation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int         MEM_DEPTH = 16;
  localparam int         PW        = $clog2(MEM_DEPTH);
  localparam int         HP        = 10;
  localparam int         H2        = HP / 2;
  localparam logic [6:0] SADDR     = 7'h22;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          scl   = 1'b1;
  logic          msda  = 1'b1;
  logic          sda_o, busy_o, wr_stb_o, rd_stb_o, sda_bus;
  logic [PW-1:0] wr_ptr_o;
  logic [7:0]    wr_data_o, rd_data_o;

  assign sda_bus = msda & sda_o;

  always #5 clk = ~clk;

  i2c_target_responder #(.SLAVE_ADDR(SADDR), .MEM_DEPTH(MEM_DEPTH), .FILT_CYCLES(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o),
    .busy_o(busy_o), .wr_stb_o(wr_stb_o), .wr_ptr_o(wr_ptr_o), .wr_data_o(wr_data_o),
    .rd_stb_o(rd_stb_o), .rd_data_o(rd_data_o)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  mem_m [MEM_DEPTH];
  int          ptr_m    = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  bit          quiet    = 1'b0;
  bit          saw_addr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare process: strobes against the expected queues, quiet-bus rules
  initial begin
    logic [15:0] e;
    logic [7:0]  r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (wr_stb_o || rd_stb_o)
          check("strobe_overlap", 32'(wr_stb_o & rd_stb_o), 32'd0);
        if (wr_stb_o) begin
          check("wr_stb_expected", 32'(exp_wr.size() > 0), 32'd1);
          if (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            check("wr_ptr", 32'(wr_ptr_o), 32'(e[15:8]));
            check("wr_data", 32'(wr_data_o), 32'(e[7:0]));
          end
        end
        if (rd_stb_o) begin
          check("rd_stb_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) begin
            r = exp_rd.pop_front();
            check("rd_data", 32'(rd_data_o), 32'(r));
          end
        end
        if (quiet) begin
          check("quiet_sda", 32'(sda_o), 32'd1);
          check("quiet_busy", 32'(busy_o), 32'd0);
        end
        if (dut.state_q == ST_ADDR) saw_addr = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_cyc(H2); msda = 1'b1; wait_cyc(H2); scl = 1'b1; wait_cyc(HP);
    end
    msda = 1'b0; wait_cyc(HP); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_cyc(H2); msda = 1'b0; wait_cyc(H2); scl = 1'b1; wait_cyc(HP); msda = 1'b1; wait_cyc(HP);
  endtask

  task automatic send_bit(input logic b, output logic s);
    wait_cyc(H2); msda = b; wait_cyc(H2); scl = 1'b1;
    wait_cyc(H2); s = sda_bus; wait_cyc(H2); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~mack, s);
  endtask

  // Write transaction: pointer then len data bytes (len may be 0)
  task automatic do_write(input logic [7:0] p, input logic [7:0] data [4], input int len);
    logic ack;
    bus_start();
    write_byte({SADDR, I2C_RW_WRITE}, ack);
    check("wr_addr_ack", 32'(ack), 32'd1);
    check("busy_after_match", 32'(busy_o), 32'd1);
    write_byte(p, ack);
    check("ptr_ack", 32'(ack), 32'd1);
    ptr_m = int'(p) % MEM_DEPTH;
    for (int i = 0; i < len; i++) begin
      exp_wr.push_back({8'(ptr_m), data[i]});
      mem_m[ptr_m] = data[i];
      ptr_m = (ptr_m + 1) % MEM_DEPTH;
      write_byte(data[i], ack);
      check("data_ack", 32'(ack), 32'd1);
    end
    bus_stop();
    check("busy_after_stop", 32'(busy_o), 32'd0);
    check("wr_pending", 32'(exp_wr.size()), 32'd0);
  endtask

  // Read transaction, optionally preceded by a pointer write and Sr
  task automatic do_read(input logic [7:0] p, input bit set_ptr, input int len,
                         output logic [7:0] got [4]);
    logic       ack;
    logic [7:0] want [4];
    if (set_ptr) begin
      bus_start();
      write_byte({SADDR, I2C_RW_WRITE}, ack);
      check("rd_waddr_ack", 32'(ack), 32'd1);
      write_byte(p, ack);
      check("rd_ptr_ack", 32'(ack), 32'd1);
      ptr_m = int'(p) % MEM_DEPTH;
    end
    for (int i = 0; i < len; i++) begin
      want[i] = mem_m[ptr_m];
      exp_rd.push_back(want[i]);
      ptr_m = (ptr_m + 1) % MEM_DEPTH;
    end
    bus_start();
    write_byte({SADDR, I2C_RW_READ}, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < len; i++) begin
      read_byte(i != len - 1, got[i]);
      check("rd_byte", 32'(got[i]), 32'(want[i]));
    end
    check("busy_after_nack", 32'(busy_o), 32'd0);
    check("sda_after_nack", 32'(sda_o), 32'd1);
    bus_stop();
    check("rd_pending", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic do_mismatch(input logic [7:0] addr_byte);
    logic ack;
    quiet = 1'b1;
    bus_start();
    write_byte(addr_byte, ack);
    check("mismatch_nack", 32'(ack), 32'd0);
    write_byte(8'h00, ack);
    check("mismatch_data_nack", 32'(ack), 32'd0);
    bus_stop();
    quiet = 1'b0;
  endtask

  initial begin
    logic [7:0] wd [4];
    logic [7:0] got [4];
    logic [7:0] p;
    logic [6:0] a;
    logic       ack;
    int         kind, len;
    bit         exp_glitch;

    for (int i = 0; i < MEM_DEPTH; i++) mem_m[i] = 8'h00;
    wait_cyc(3);
    check("rst_sda", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_wr_stb", 32'(wr_stb_o), 32'd0);
    check("rst_rd_stb", 32'(rd_stb_o), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_rd_data", 32'(rd_data_o), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Write 0xA5, 0x5A from pointer 3, then read them back via Sr
    wd = '{8'hA5, 8'h5A, 8'h00, 8'h00};
    do_write(8'h03, wd, 2);
    do_read(8'h03, 1'b1, 2, got);
    check("lit_rd0", 32'(got[0]), 32'hA5);
    check("lit_rd1", 32'(got[1]), 32'h5A);

    do_mismatch(8'h46);

    // Pointer wrap and masking
    wd = '{8'h11, 8'h22, 8'h00, 8'h00};
    do_write(8'h0F, wd, 2);
    wd = '{8'h33, 8'h00, 8'h00, 8'h00};
    do_write(8'h13, wd, 1);
    do_read(8'h0F, 1'b1, 2, got);
    check("lit_wrap15", 32'(got[0]), 32'h11);
    check("lit_wrap0", 32'(got[1]), 32'h22);
    do_read(8'h03, 1'b1, 1, got);
    check("lit_mask3", 32'(got[0]), 32'h33);

    // Reset while the target drives bit 7 (0) of 0x5A at location 4
    bus_start();
    write_byte({SADDR, I2C_RW_WRITE}, ack);
    write_byte(8'h04, ack);
    ptr_m = 4;
    exp_rd.push_back(mem_m[4]);
    bus_start();
    write_byte({SADDR, I2C_RW_READ}, ack);
    check("rst_rd_addr_ack", 32'(ack), 32'd1);
    wait_cyc(HP - 2);
    check("sda_drive_bit7", 32'(sda_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("sda_async_release", 32'(sda_o), 32'd1);
    for (int i = 0; i < MEM_DEPTH; i++) mem_m[i] = 8'h00;
    ptr_m = 0;
    exp_wr.delete();
    exp_rd.delete();
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    bus_stop();
    do_read(8'h00, 1'b0, 1, got);
    check("lit_after_reset", 32'(got[0]), 32'h00);

    // 2-cycle sda low pulse while scl is high and the bus idle
`ifdef I2C_RESP_GLITCH_FILTER_EN
    exp_glitch = 1'b0;
`else
    exp_glitch = 1'b1;
`endif
    wait_cyc(5);
    saw_addr = 1'b0;
    msda = 1'b0;
    wait_cyc(2);
    msda = 1'b1;
    wait_cyc(20);
    check("glitch_start_seen", 32'(saw_addr), 32'(exp_glitch));

    // Randomized transactions against the model
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      p    = 8'($urandom_range(0, 255));
      len  = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wd[i] = 8'($urandom_range(0, 255));
      case (kind)
        0: do_write(p, wd, len);
        1: do_read(p, 1'b1, len, got);
        2: begin
          do_write(p, wd, 0);
          do_read(8'h00, 1'b0, len, got);
        end
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == SADDR) a = a + 7'd1;
          do_mismatch({a, 1'($urandom_range(0, 1))});
        end
      endcase
    end

    wait_cyc(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
